// File: rtl/teclado_cajero.sv
// 4x4 matrix keypad scanner for the ATM controller: synchronizes and debounces the columns,
// then emits one strobe per keypress on the digit path (0-9) or the command path (A-F).
module teclado_cajero #(
   parameter int SCAN_CYCLES     = 4,
   parameter int DEBOUNCE_CYCLES = 16,
   parameter int CNT_W           = 8
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [3:0] columnas,
   output logic [3:0] filas,
   output logic [3:0] digito,
   output logic       digito_stb,
   output logic [3:0] comando,
   output logic       comando_stb
);

   typedef enum logic [1:0] {
      ESCANEO   = 2'd0,
      CONFIRMAR = 2'd1,
      EMITIR    = 2'd2,
      LIBERAR   = 2'd3
   } estado_t;

   localparam logic [CNT_W-1:0] SCAN_LAST = CNT_W'(SCAN_CYCLES - 1);
   localparam logic [CNT_W-1:0] DEB_TOP   = CNT_W'(DEBOUNCE_CYCLES);

   // Key code for a (row, column) position of the keypad matrix.
   function automatic logic [3:0] key_code(input logic [1:0] fila, input logic [1:0] col);
      logic [3:0] code;
      case ({fila, col})
         4'd0:    code = 4'h1;
         4'd1:    code = 4'h2;
         4'd2:    code = 4'h3;
         4'd3:    code = 4'hA;
         4'd4:    code = 4'h4;
         4'd5:    code = 4'h5;
         4'd6:    code = 4'h6;
         4'd7:    code = 4'hB;
         4'd8:    code = 4'h7;
         4'd9:    code = 4'h8;
         4'd10:   code = 4'h9;
         4'd11:   code = 4'hC;
         4'd12:   code = 4'hE;
         4'd13:   code = 4'h0;
         4'd14:   code = 4'hF;
         4'd15:   code = 4'hD;
         default: code = 4'h0;
      endcase
      return code;
   endfunction

   function automatic logic es_onehot(input logic [3:0] v);
      return (v != 4'd0) && ((v & (v - 4'd1)) == 4'd0);
   endfunction

   function automatic logic [1:0] col_index(input logic [3:0] v);
      logic [1:0] idx;
      case (v)
         4'b0010: idx = 2'd1;
         4'b0100: idx = 2'd2;
         4'b1000: idx = 2'd3;
         default: idx = 2'd0;
      endcase
      return idx;
   endfunction

   logic [3:0]       col_meta_r, col_s;
   estado_t          estado_r, estado_s;
   logic [1:0]       fila_r, fila_s;
   logic [1:0]       col_idx_r, col_idx_s;
   logic [CNT_W-1:0] slot_r, slot_s;
   logic [CNT_W-1:0] deb_r, deb_s;
   logic [3:0]       filas_r;
   logic [3:0]       digito_r, digito_s;
   logic [3:0]       comando_r, comando_s;
   logic             digito_stb_r, digito_stb_s;
   logic             comando_stb_r, comando_stb_s;
   logic [3:0]       code_s;

   // Next-state and next-output logic of the scan/debounce FSM.
   always_comb begin
      estado_s      = estado_r;
      fila_s        = fila_r;
      col_idx_s     = col_idx_r;
      slot_s        = slot_r;
      deb_s         = deb_r;
      digito_s      = digito_r;
      comando_s     = comando_r;
      digito_stb_s  = 1'b0;
      comando_stb_s = 1'b0;
      code_s        = key_code(fila_r, col_idx_r);
      case (estado_r)
         ESCANEO: begin
            if (slot_r == SCAN_LAST) begin
               slot_s = {CNT_W{1'b0}};
               if (es_onehot(col_s)) begin
                  estado_s  = CONFIRMAR;
                  col_idx_s = col_index(col_s);
                  deb_s     = CNT_W'(1);
               end else begin
                  fila_s = fila_r + 2'd1;
               end
            end else begin
               slot_s = slot_r + CNT_W'(1);
            end
         end
         CONFIRMAR: begin
            if (col_s == (4'b0001 << col_idx_r)) begin
               if (deb_r + CNT_W'(1) == DEB_TOP) begin
                  // Strobe and code register are loaded together so both are valid during EMITIR.
                  estado_s = EMITIR;
                  deb_s    = {CNT_W{1'b0}};
                  if (code_s < 4'd10) begin
                     digito_stb_s = 1'b1;
                     digito_s     = code_s;
                  end else begin
                     comando_stb_s = 1'b1;
                     comando_s     = code_s;
                  end
               end else begin
                  deb_s = deb_r + CNT_W'(1);
               end
            end else begin
               estado_s = ESCANEO;
               fila_s   = fila_r + 2'd1;
               slot_s   = {CNT_W{1'b0}};
               deb_s    = {CNT_W{1'b0}};
            end
         end
         EMITIR: begin
            estado_s = LIBERAR;
            deb_s    = {CNT_W{1'b0}};
         end
         LIBERAR: begin
            if (col_s == 4'd0) begin
               if (deb_r + CNT_W'(1) == DEB_TOP) begin
                  estado_s = ESCANEO;
                  fila_s   = 2'd0;
                  slot_s   = {CNT_W{1'b0}};
                  deb_s    = {CNT_W{1'b0}};
               end else begin
                  deb_s = deb_r + CNT_W'(1);
               end
            end else begin
               deb_s = {CNT_W{1'b0}};
            end
         end
         default: begin
            estado_s = ESCANEO;
            fila_s   = 2'd0;
            slot_s   = {CNT_W{1'b0}};
            deb_s    = {CNT_W{1'b0}};
         end
      endcase
   end

   // Column synchronizer plus all FSM state and output registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         col_meta_r    <= 4'd0;
         col_s         <= 4'd0;
         estado_r      <= ESCANEO;
         fila_r        <= 2'd0;
         col_idx_r     <= 2'd0;
         slot_r        <= {CNT_W{1'b0}};
         deb_r         <= {CNT_W{1'b0}};
         filas_r       <= 4'b0001;
         digito_r      <= 4'd0;
         comando_r     <= 4'd0;
         digito_stb_r  <= 1'b0;
         comando_stb_r <= 1'b0;
      end else begin
         col_meta_r    <= columnas;
         col_s         <= col_meta_r;
         estado_r      <= estado_s;
         fila_r        <= fila_s;
         col_idx_r     <= col_idx_s;
         slot_r        <= slot_s;
         deb_r         <= deb_s;
         filas_r       <= 4'b0001 << fila_s;
         digito_r      <= digito_s;
         comando_r     <= comando_s;
         digito_stb_r  <= digito_stb_s;
         comando_stb_r <= comando_stb_s;
      end
   end

   assign filas       = filas_r;
   assign digito      = digito_r;
   assign comando     = comando_r;
   assign digito_stb  = digito_stb_r;
   assign comando_stb = comando_stb_r;

endmodule

// File: tb/tb_teclado_cajero.sv
// Directed bench for teclado_cajero: a keypad matrix model drives columnas from filas and
// the held-key mask; strobes are counted and checked against hand-computed expectations.
module tb_teclado_cajero;

   logic        clk = 1'b0;
   logic        reset;
   logic [3:0]  columnas;
   logic [3:0]  filas;
   logic [3:0]  digito;
   logic        digito_stb;
   logic [3:0]  comando;
   logic        comando_stb;
   logic [15:0] held;

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int n_dig = 0;
   int n_com = 0;
   int n_both = 0;
   int last_dig_cyc = -1;
   int d0, c0, t0, w;

   teclado_cajero dut (
      .clk(clk), .reset(reset), .columnas(columnas), .filas(filas),
      .digito(digito), .digito_stb(digito_stb), .comando(comando), .comando_stb(comando_stb)
   );

   always #5 clk = ~clk;

   // Key at (r,c) connects row r to column c while pressed.
   always_comb begin
      columnas = 4'd0;
      for (int r = 0; r < 4; r++)
         for (int c = 0; c < 4; c++)
            if (held[r*4+c] && filas[r]) columnas[c] = 1'b1;
   end

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (digito_stb) begin
         n_dig        <= n_dig + 1;
         last_dig_cyc <= cyc;
      end
      if (comando_stb) n_com <= n_com + 1;
      if (digito_stb && comando_stb) n_both <= n_both + 1;
   end

   task automatic step(input int n);
      repeat (n) begin
         @(negedge clk);
         #1;
      end
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   initial begin
      held  = 16'd0;
      reset = 1'b1;
      step(3);
      check("rst_filas", 32'(filas), 32'h1);
      check("rst_digito", 32'(digito), 32'h0);
      check("rst_comando", 32'(comando), 32'h0);
      check("rst_dstb", 32'(digito_stb), 32'h0);
      check("rst_cstb", 32'(comando_stb), 32'h0);

      // Idle rotation: each row for 4 cycles.
      reset = 1'b0;
      for (int k = 0; k < 16; k++) begin
         if (k != 0) step(1);
         check("scan_filas", 32'(filas), 32'(4'b0001 << ((k / 4) % 4)));
      end
      step(48);
      check("idle_no_dstb", 32'(n_dig), 32'd0);
      check("idle_no_cstb", 32'(n_com), 32'd0);

      // "5" held 100 cycles.
      d0 = n_dig; c0 = n_com;
      held[5] = 1'b1; step(100); held = 16'd0; step(40);
      check("k5_count", 32'(n_dig - d0), 32'd1);
      check("k5_digito", 32'(digito), 32'h5);
      check("k5_comando", 32'(comando), 32'h0);
      check("k5_no_cstb", 32'(n_com - c0), 32'd0);

      // "#" held 100 cycles.
      d0 = n_dig; c0 = n_com;
      held[14] = 1'b1; step(100); held = 16'd0; step(40);
      check("kh_count", 32'(n_com - c0), 32'd1);
      check("kh_comando", 32'(comando), 32'hF);
      check("kh_no_dstb", 32'(n_dig - d0), 32'd0);
      check("kh_digito_kept", 32'(digito), 32'h5);

      // "7" with bounce, then stable.
      d0 = n_dig;
      for (int b = 0; b < 10; b++) begin
         held[8] = 1'b1; step(3);
         held[8] = 1'b0; step(2);
      end
      held[8] = 1'b1; t0 = cyc; step(40); held = 16'd0; step(40);
      check("k7_count", 32'(n_dig - d0), 32'd1);
      check("k7_digito", 32'(digito), 32'h7);
      check("k7_after_stable", 32'(last_dig_cyc > t0 + 15), 32'd1);

      // Two keys in row 0 (columnas=0011) are ignored.
      d0 = n_dig; c0 = n_com;
      held[0] = 1'b1; held[1] = 1'b1; step(50); held = 16'd0; step(20);
      check("multi_no_dstb", 32'(n_dig - d0), 32'd0);
      check("multi_no_cstb", 32'(n_com - c0), 32'd0);

      // "0" with a short release between presses gives one strobe.
      d0 = n_dig;
      held[13] = 1'b1; step(60);
      held = 16'd0; step(5);
      held[13] = 1'b1; step(60);
      held = 16'd0; step(40);
      check("k0_count", 32'(n_dig - d0), 32'd1);
      check("k0_digito", 32'(digito), 32'h0);

      // "9" pressed at the start of row 2, reset while confirming.
      w = 0;
      while (filas === 4'b0100 && w < 20) begin step(1); w++; end
      while (filas !== 4'b0100 && w < 40) begin step(1); w++; end
      check("wait_row2", 32'(filas === 4'b0100), 32'd1);
      d0 = n_dig;
      held[10] = 1'b1; step(8);
      reset = 1'b1; step(1);
      check("k9_rst_filas", 32'(filas), 32'h1);
      check("k9_rst_digito", 32'(digito), 32'h0);
      step(1);
      reset = 1'b0;
      check("k9_rst_no_stb", 32'(n_dig - d0), 32'd0);
      step(100); held = 16'd0; step(40);
      check("k9_count", 32'(n_dig - d0), 32'd1);
      check("k9_digito", 32'(digito), 32'h9);

      check("never_both", 32'(n_both), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/teclado_cajero.md
Name: teclado_cajero

Overview:
- Upstream stage of the ATM controller: scans a 4x4 matrix keypad, synchronizes and debounces the column inputs, and emits one single-cycle strobe per physical keypress.
- Numeric keys (0-9) drive digito/digito_stb, which connect directly to the controller's digito/digito_stb inputs.
- Non-numeric keys (A-D, *, #) are reported separately on comando/comando_stb for the transaction-selection logic.

Parameters:
- SCAN_CYCLES, 4: cycles each row stays driven. Legal range ≥3, covering the 2-flop sync latency plus 1 sample cycle.
- DEBOUNCE_CYCLES, 16: consecutive identical samples required for both press confirmation and release confirmation. Legal range ≥2.
- CNT_W, 8: width of the scan and debounce counters. Must satisfy 2^CNT_W > max(SCAN_CYCLES, DEBOUNCE_CYCLES).

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- reset  input  1  synchronous reset, active-high.
- columnas  input  4  keypad column lines; asynchronous, active-high (external pull-downs).
- filas  output  4  row drive, one-hot, active-high.
- digito  output  4  code of the last numeric key (0-9).
- digito_stb  output  1  one-cycle pulse; digito is valid in the same cycle.
- comando  output  4  code of the last non-numeric key (A..F).
- comando_stb  output  1  one-cycle pulse; comando is valid in the same cycle.

Behaviour:
- Reset values (synchronous, checked at the clock edge):
  - filas=4'b0001; digito=0; digito_stb=0; comando=0; comando_stb=0.
  - FSM=ESCANEO; row index=0; all counters=0; both synchronizer stages=0.
  - Reset asserted mid-operation aborts everything; no strobe is emitted for a press in progress.
- Synchronizer: columnas passes through 2 flops, producing col_s. All decisions use col_s only.
- Key map, row r (filas bit r) x column c (columnas bit c):
  - r0: 1, 2, 3, A
  - r1: 4, 5, 6, B
  - r2: 7, 8, 9, C
  - r3: E(*), 0, F(#), D
- Only 0x0-0x9 go to the digito path; A-F go to the comando path.
- FSM ESCANEO:
  - filas rotates 0001→0010→0100→1000→0001, advancing every SCAN_CYCLES cycles.
  - col_s is sampled only in the last cycle of each row slot.
  - col_s one-hot: latch row and column, debounce counter=1, go to CONFIRMAR; filas holds.
  - col_s zero or multi-bit (ghosting / multiple keys): ignore and continue the rotation.
- FSM CONFIRMAR:
  - Each cycle col_s equals the latched column: counter increments.
  - Counter reaches DEBOUNCE_CYCLES: go to EMITIR.
  - col_s differs (including 0 or multi-bit): abandon, go to ESCANEO, resume at the next row with a fresh slot.
- FSM EMITIR (exactly 1 cycle):
  - Assert digito_stb or comando_stb, never both.
  - Update the matching code register; the other code register keeps its value.
  - Go to LIBERAR.
- FSM LIBERAR:
  - filas holds the latched row.
  - Counter counts consecutive cycles with col_s==0; any nonzero col_s resets it to 0.
  - Counter reaches DEBOUNCE_CYCLES: go to ESCANEO at row 0, slot counter 0.
  - A key held indefinitely produces exactly one strobe (no auto-repeat).
- Outputs:
  - Strobes are registered.
  - digito and comando hold their values until the next respective strobe.
- Latency: a press stable from cycle t yields a strobe no later than t + 4*SCAN_CYCLES + DEBOUNCE_CYCLES + 3.
- A new press during LIBERAR (a second key while the first is still held) is never reported. Both keys must be released before scanning resumes.

Test Plan:
- Reset, then release reset with no key held → filas cycles 0001,0010,0100,1000 every 4 cycles; no strobes for 64 cycles.
- Hold r1/c1 ("5") for 100 cycles, then release → exactly one digito_stb; digito=4'h5 in that cycle; comando unchanged at 0.
- Hold r3/c2 ("#") for 100 cycles → exactly one comando_stb with comando=4'hF; digito_stb stays 0.
- Press "7" as bounce pulses shorter than DEBOUNCE_CYCLES (on 3, off 2, repeated 10 times), then stable for 40 cycles → exactly one digito_stb with digito=4'h7, occurring after the stable window.
- Assert columnas=4'b0011 during r0 → no strobe. Hold "0", release for 5 cycles, re-press → still only one strobe, because release was not debounced.
- Assert reset during CONFIRMAR for "9" → no strobe; filas=0001 on the cycle after reset. Hold "9" for 100 cycles after reset deasserts → one digito_stb with digito=4'h9.
